// File: rtl/t_vals_gen.sv
// Per-frame lag-product accumulator feeding the formant/phi stage: T(nu) = sum x[n]*x[n-nu].
// Latency: output_start 1 cycle after frame accept, beats 2 cycles after closing sample; no backpressure.
module t_vals_gen #(
  parameter int BIT_WIDTH    = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int I            = 160,
  parameter int FORMANTS     = 5,
  parameter int NU_VALUES    = 3
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic [SAMPLE_WIDTH-1:0]                       sample_in,
  input  logic                                          sample_valid_in,
  input  logic                                          frame_start_in,
  input  logic [FORMANTS-1:0][$clog2(I+1)-1:0]          seg_bounds_in,
  output logic [NU_VALUES-1:0][BIT_WIDTH-1:0]           T_vals,
  output logic                                          output_start,
  output logic                                          output_valid,
  output logic                                          busy
);

  localparam int NW = $clog2(I+1);
  localparam int KW = $clog2(FORMANTS+1);
  localparam int PW = 2*SAMPLE_WIDTH;
  localparam logic [NW-1:0] LAST_N = NW'(I-1);
  localparam logic [KW-1:0] NUM_K  = KW'(FORMANTS);
  localparam logic [KW-1:0] LAST_K = KW'(FORMANTS-1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                                   state_q, state_d;
  logic [FORMANTS-1:0][NW-1:0]              bounds_q;
  logic [NW-1:0]                            n_q, n_d;
  logic [KW-1:0]                            k_q, k_d;
  logic [NU_VALUES-1:0][SAMPLE_WIDTH-1:0]   hist_q;

  logic                                     start_evt, take, flush_go, close, last, hit, frame_end;
  logic [NW-1:0]                            cur_n;
  logic [KW-1:0]                            cur_k;
  logic [FORMANTS-1:0][NW-1:0]              cur_b;
  logic [NU_VALUES-1:0][SAMPLE_WIDTH-1:0]   taps;
  logic [NU_VALUES-1:0][PW-1:0]             prod_full;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0]      prod_d;

  logic                                     s1_vld, s1_clr, s1_close, s1_last;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0]      s1_prod;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0]      acc_q, acc_sum;
  logic                                     out_last;
  logic                                     emit;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    start_evt = sample_valid_in & frame_start_in;
    take      = start_evt | ((state_q == ACCUM) & sample_valid_in);
    flush_go  = (state_q == FLUSH) & ~start_evt;
    // A new frame restarts from a clean slate regardless of the current state.
    cur_n     = start_evt ? '0 : n_q;
    cur_k     = start_evt ? '0 : k_q;
    cur_b     = start_evt ? seg_bounds_in : bounds_q;
    frame_end = (cur_n == LAST_N);
    hit       = 1'b0;
    for (int j = 0; j < FORMANTS; j++) begin
      if ((KW'(j) == cur_k) && (({1'b0, cur_n} + 1'b1) == {1'b0, cur_b[j]})) hit = 1'b1;
    end
    close     = 1'b0;
    last      = 1'b0;
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    if (take) begin
      // The last sample also carries the first flush beat, so FLUSH starts right behind it.
      close   = hit | (frame_end & (cur_k < NUM_K));
      last    = close & (cur_k == LAST_K);
      n_d     = cur_n + 1'b1;
      k_d     = cur_k + KW'(close);
      if (frame_end) state_d = (k_d < NUM_K) ? FLUSH : IDLE;
      else           state_d = ACCUM;
    end else if (flush_go) begin
      close   = 1'b1;
      last    = (k_q == LAST_K);
      k_d     = k_q + 1'b1;
      state_d = last ? IDLE : FLUSH;
    end
  end

  always_comb begin
    taps    = '0;
    taps[0] = sample_in;
    for (int j = 1; j < NU_VALUES; j++) begin
      taps[j] = start_evt ? '0 : hist_q[j-1];
    end
    for (int j = 0; j < NU_VALUES; j++) begin
      prod_full[j] = $signed(taps[j]) * $signed(sample_in);
      prod_d[j]    = BIT_WIDTH'($signed(prod_full[j]));
      acc_sum[j]   = (s1_clr ? '0 : acc_q[j]) + s1_prod[j];
    end
    // Anything in stage 1 when a new frame is accepted belongs to the aborted frame.
    emit = s1_vld & s1_close & ~start_evt;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      n_q          <= '0;
      k_q          <= '0;
      bounds_q     <= '0;
      hist_q       <= '0;
      s1_vld       <= 1'b0;
      s1_clr       <= 1'b0;
      s1_close     <= 1'b0;
      s1_last      <= 1'b0;
      s1_prod      <= '0;
      acc_q        <= '0;
      T_vals       <= '0;
      output_start <= 1'b0;
      output_valid <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      n_q          <= n_d;
      k_q          <= k_d;
      if (start_evt) bounds_q <= seg_bounds_in;
      if (take)      hist_q   <= taps;
      s1_vld       <= take | flush_go;
      s1_clr       <= start_evt;
      s1_close     <= close;
      s1_last      <= last;
      s1_prod      <= take ? prod_d : '0;
      if (s1_vld) acc_q <= acc_sum;
      if (emit)   T_vals <= acc_sum;
      output_start <= start_evt;
      output_valid <= emit;
      out_last     <= emit & s1_last;
      busy         <= start_evt | (busy & ~(output_valid & out_last));
    end
  end

endmodule

// File: tb/tb_t_vals_gen.sv
// Directed bench for t_vals_gen: constant, alternating, bubbles, duplicate bounds, abort and mid-frame reset.
module tb_t_vals_gen;

  localparam int BW = 32;
  localparam int SW = 16;
  localparam int I  = 160;
  localparam int F  = 5;
  localparam int NU = 3;
  localparam int NW = $clog2(I+1);

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [SW-1:0]            sample_in;
  logic                     sample_valid_in;
  logic                     frame_start_in;
  logic [F-1:0][NW-1:0]     seg_bounds_in;
  logic [NU-1:0][BW-1:0]    T_vals;
  logic                     output_start;
  logic                     output_valid;
  logic                     busy;

  t_vals_gen #(.BIT_WIDTH(BW), .SAMPLE_WIDTH(SW), .I(I), .FORMANTS(F), .NU_VALUES(NU)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .frame_start_in(frame_start_in), .seg_bounds_in(seg_bounds_in), .T_vals(T_vals),
    .output_start(output_start), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int          st_cyc[$];
  int          bt_cyc[$];
  logic [31:0] bt_t0[$], bt_t1[$], bt_t2[$];
  int          samp_cyc[I];

  always @(negedge clk_in) begin
    if (output_start) st_cyc.push_back(cyc);
    if (output_valid) begin
      bt_cyc.push_back(cyc);
      bt_t0.push_back(T_vals[0]);
      bt_t1.push_back(T_vals[1]);
      bt_t2.push_back(T_vals[2]);
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] sval(input int mode, input int n);
    if (mode == 0) return 32'd1;
    return (n % 2 == 0) ? 32'd1000 : -32'sd1000;
  endfunction

  // Hand formula: constant x=1 gives b-nu; alternating +-1000 gives (-1)^nu * (b-nu) * 1e6.
  function automatic logic [31:0] exp_t(input int mode, input int b, input int nu);
    int v;
    if (mode == 0) return 32'(b - nu);
    v = (b - nu) * 1000000;
    return (nu % 2 == 1) ? 32'(-v) : 32'(v);
  endfunction

  task automatic clear_q();
    st_cyc.delete(); bt_cyc.delete(); bt_t0.delete(); bt_t1.delete(); bt_t2.delete();
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk_in); #1;
      sample_valid_in = 1'b0; frame_start_in = 1'b0;
    end
  endtask

  task automatic run_frame(input int mode, input int bub, input int stop_at);
    int n = 0;
    while (n < I && (stop_at < 0 || n < stop_at)) begin
      @(posedge clk_in); #1;
      if (bub > 0 && n > 0 && $urandom_range(99) < bub) begin
        sample_valid_in = 1'b0;
        frame_start_in  = 1'($urandom_range(1));
        sample_in       = 16'($urandom);
      end else begin
        sample_valid_in = 1'b1;
        frame_start_in  = (n == 0);
        sample_in       = 16'(sval(mode, n));
        samp_cyc[n]     = cyc;
        n++;
      end
    end
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0; frame_start_in = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int idx, input int ecyc,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    if (idx < bt_cyc.size()) begin
      chk({tag, "_cyc"}, 32'(bt_cyc[idx]), 32'(ecyc));
      chk({tag, "_t0"},  bt_t0[idx], e0);
      chk({tag, "_t1"},  bt_t1[idx], e1);
      chk({tag, "_t2"},  bt_t2[idx], e2);
    end
  endtask

  task automatic chk_std(input string tag, input int mode, input int off);
    for (int k = 1; k <= F; k++) begin
      chk_beat($sformatf("%s_b%0d", tag, k), off + k - 1, samp_cyc[32*k-1] + 2,
               exp_t(mode, 32*k, 0), exp_t(mode, 32*k, 1), exp_t(mode, 32*k, 2));
    end
  endtask

  task automatic std_frame(input string tag, input int mode, input int bub);
    clear_q();
    run_frame(mode, bub, -1);
    idle(12);
    chk({tag, "_starts"}, 32'(st_cyc.size()), 32'd1);
    if (st_cyc.size() > 0) chk({tag, "_start_cyc"}, 32'(st_cyc[0]), 32'(samp_cyc[0] + 1));
    chk({tag, "_beats"}, 32'(bt_cyc.size()), 32'd5);
    chk_std(tag, mode, 0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s31_first;
    rst_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0; frame_start_in = 1'b0;
    for (int j = 0; j < F; j++) seg_bounds_in[j] = NW'(32*(j+1));
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_t0", T_vals[0], 32'd0);
    chk("rst_t1", T_vals[1], 32'd0);
    chk("rst_t2", T_vals[2], 32'd0);
    chk("rst_start", 32'(output_start), 32'd0);
    chk("rst_valid", 32'(output_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_in = 1'b1;
    idle(2);

    std_frame("const", 0, 0);
    std_frame("alt", 1, 0);
    std_frame("bubble", 0, 30);

    // Duplicate bounds: one real close, the rest flushed behind the last sample.
    for (int j = 0; j < F; j++) seg_bounds_in[j] = NW'(10);
    clear_q();
    run_frame(0, 0, -1);
    idle(12);
    chk("dup_starts", 32'(st_cyc.size()), 32'd1);
    chk("dup_beats", 32'(bt_cyc.size()), 32'd5);
    chk_beat("dup_b1", 0, samp_cyc[9] + 2, 32'd10, 32'd9, 32'd8);
    for (int j = 1; j < F; j++)
      chk_beat($sformatf("dup_f%0d", j), j, samp_cyc[I-1] + 1 + j, 32'd160, 32'd159, 32'd158);

    // Abort at sample 50: first frame contributes only the bound-32 beat.
    for (int j = 0; j < F; j++) seg_bounds_in[j] = NW'(32*(j+1));
    clear_q();
    run_frame(0, 0, 50);
    s31_first = samp_cyc[31];
    run_frame(0, 0, -1);
    idle(12);
    chk("abort_starts", 32'(st_cyc.size()), 32'd2);
    if (st_cyc.size() > 1) chk("abort_start2_cyc", 32'(st_cyc[1]), 32'(samp_cyc[0] + 1));
    chk("abort_beats", 32'(bt_cyc.size()), 32'd6);
    chk_beat("abort_old", 0, s31_first + 2, 32'd32, 32'd31, 32'd30);
    chk_std("abort_new", 0, 1);

    // Reset at sample 70 discards the frame; afterwards a normal frame.
    clear_q();
    run_frame(0, 0, 70);
    @(posedge clk_in); #1;
    rst_in = 1'b0; sample_valid_in = 1'b1; sample_in = 16'd1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    chk("mrst_t0", T_vals[0], 32'd0);
    chk("mrst_t1", T_vals[1], 32'd0);
    chk("mrst_valid", 32'(output_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    rst_in = 1'b1;
    idle(200);
    chk("mrst_beats", 32'(bt_cyc.size()), 32'd2);
    chk("mrst_starts", 32'(st_cyc.size()), 32'd1);
    std_frame("post_rst", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
